// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder and its LFSR.
// Also hosts the Galois step so every LFSR user advances identically.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REFRAC = 2'd2,
    DONE   = 2'd3
  } enc_state_e;

  localparam logic        MODE_DET       = 1'b0;
  localparam logic        MODE_STOCH     = 1'b1;
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;

  // Right-shifting Galois form: feedback bit is the LSB shifted out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) with advance enable.
// The seed must be nonzero or the register locks up at zero.
module spike_lfsr import spike_enc_pkg::*; #(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)        lfsr_q <= SEED;
    else if (adv_i) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-to-spike-train encoder feeding the LIF neuron's signal_in.
// Deterministic (accumulator carry) or stochastic (LFSR compare) firing.
module spike_rate_encoder import spike_enc_pkg::*; #(
  parameter int          WIDTH     = 8,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_rate,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_count,
  input  logic [3:0]       cfg_refrac,
  input  logic             enable,
  input  logic             stop,
  output logic             spike_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] spike_cnt
);

  enc_state_e       state_q;
  logic [WIDTH-1:0] rate_q;
  logic             mode_q;
  logic [7:0]       count_q;
  logic [3:0]       refrac_q;
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       rcnt_q;
  logic [7:0]       burst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             spike_q;
  logic             busy_q;
  logic             done_q;

  logic [15:0]      lfsr_w;
  logic             lfsr_unused;

  // The LFSR free-runs on enable so the random stream is independent of config timing.
  spike_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (enable),
    .state_o (lfsr_w)
  );

  assign lfsr_unused = ^lfsr_w[15:WIDTH];

  logic [WIDTH:0]   sum_d;
  logic             fire_d;
  logic [7:0]       burst_d;
  logic             last_d;
  logic [CNT_W-1:0] cnt_d;

  assign sum_d   = {1'b0, acc_q} + {1'b0, rate_q};
  assign fire_d  = (mode_q == MODE_STOCH) ? (lfsr_w[WIDTH-1:0] < rate_q) : sum_d[WIDTH];
  assign burst_d = burst_q + 8'd1;
  assign last_d  = (count_q != 8'd0) && (burst_d == count_q);
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rate_q   <= '0;
      mode_q   <= MODE_DET;
      count_q  <= '0;
      refrac_q <= '0;
      acc_q    <= '0;
      rcnt_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      spike_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            rate_q   <= cfg_rate;
            mode_q   <= cfg_mode;
            count_q  <= cfg_count;
            refrac_q <= cfg_refrac;
            acc_q    <= '0;
            cnt_q    <= '0;
            burst_q  <= '0;
            state_q  <= RUN;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (enable) begin
            if (mode_q == MODE_DET) acc_q <= sum_d[WIDTH-1:0];
            if (fire_d) begin
              spike_q <= 1'b1;
              cnt_q   <= cnt_d;
              burst_q <= burst_d;
              // Burst completion wins over refractory: no gap before DONE.
              if (last_d) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end else if (refrac_q != 4'd0) begin
                rcnt_q  <= refrac_q;
                state_q <= REFRAC;
              end
            end
          end
        end
        REFRAC: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (enable) begin
            rcnt_q <= rcnt_q - 4'd1;
            if (rcnt_q == 4'd1) state_q <= RUN;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= ~stop;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign spike_out = spike_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboarded bench for spike_rate_encoder: closed-form accumulator
// expectations, an independent Galois LFSR model and per-scenario tasks.
module tb_spike_rate_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_rate = 8'd0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_count = 8'd0;
  logic [3:0]  cfg_refrac = 4'd0;
  logic        enable = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_ready, spike_out, busy, done;
  logic [15:0] spike_cnt;
  logic        cfg_ready2, spike_out2, busy2, done2;
  logic [3:0]  spike_cnt2;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  bit          exp_q[$];

  always #5 clk = ~clk;

  spike_rate_encoder dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rate(cfg_rate), .cfg_mode(cfg_mode), .cfg_count(cfg_count),
    .cfg_refrac(cfg_refrac), .enable(enable), .stop(stop),
    .spike_out(spike_out), .busy(busy), .done(done), .spike_cnt(spike_cnt)
  );

  // Narrow counter copy to exercise saturation within a short run.
  spike_rate_encoder #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_rate(cfg_rate), .cfg_mode(cfg_mode), .cfg_count(cfg_count),
    .cfg_refrac(cfg_refrac), .enable(enable), .stop(stop),
    .spike_out(spike_out2), .busy(busy2), .done(done2), .spike_cnt(spike_cnt2)
  );

  function automatic logic [15:0] gold_lfsr(input logic [15:0] x);
    logic [15:0] y;
    y = {1'b0, x[15:1]};
    if (x[0]) y = y ^ 16'b1011_0100_0000_0000;
    return y;
  endfunction

  // Carry out of an n-th accumulation == integer part of n*rate/256 stepping up.
  function automatic bit det_fire(input int n, input int r);
    return ((n * r) / 256) != (((n - 1) * r) / 256);
  endfunction

  task automatic tick();
    logic [15:0] nxt;
    nxt = rst ? 16'hACE1 : (enable ? gold_lfsr(m_lfsr) : m_lfsr);
    @(posedge clk);
    m_lfsr = nxt;
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] r, input logic m, input logic [7:0] c, input logic [3:0] f);
    cfg_rate = r; cfg_mode = m; cfg_count = c; cfg_refrac = f; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    tick(); tick();
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    nvec++; if (spike_out !== 1'b0) begin nerr++; $display("FAIL reset_spike got %b want 0", spike_out); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    nvec++; if (spike_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", spike_cnt); end
    nvec++; if (dut.u_lfsr.state_o !== 16'hACE1) begin nerr++; $display("FAIL reset_lfsr got %h want ace1", dut.u_lfsr.state_o); end
    nvec++; if ({cfg_ready2, spike_out2, busy2, done2} !== 4'b1000 || spike_cnt2 !== 4'd0) begin
      nerr++; $display("FAIL reset_sat_copy got %b%b%b%b/%0d want 1000/0", cfg_ready2, spike_out2, busy2, done2, spike_cnt2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_det_rate128();
    bit e;
    load_cfg(8'd128, 1'b0, 8'd0, 4'd0);
    nvec++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin nerr++; $display("FAIL det_accept busy/ready got %b%b want 10", busy, cfg_ready); end
    for (int n = 1; n <= 100; n++) begin
      exp_q.push_back(det_fire(n, 128));
      tick();
      e = exp_q.pop_front();
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL det128_spike edge %0d got %b want %b", n, spike_out, e); end
      nvec++; if (spike_out2 !== e) begin nerr++; $display("FAIL det128_spike_sat edge %0d got %b want %b", n, spike_out2, e); end
    end
    nvec++; if (spike_cnt !== 16'd50) begin nerr++; $display("FAIL det128_cnt got %0d want 50", spike_cnt); end
    nvec++; if (spike_cnt2 !== 4'd15) begin nerr++; $display("FAIL det128_cnt_saturate got %0d want 15", spike_cnt2); end
    go_idle();
    nvec++; if (cfg_ready !== 1'b1 || spike_cnt !== 16'd50) begin nerr++; $display("FAIL det128_stop ready/cnt got %b/%0d want 1/50", cfg_ready, spike_cnt); end
  endtask

  task automatic test_burst();
    bit e;
    load_cfg(8'd64, 1'b0, 8'd4, 4'd0);
    for (int k = 1; k <= 18; k++) begin
      exp_q.push_back(k <= 16 && det_fire(k, 64));
      tick();
      e = exp_q.pop_front();
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL burst_spike edge %0d got %b want %b", k, spike_out, e); end
      nvec++; if (done !== (k == 17)) begin nerr++; $display("FAIL burst_done edge %0d got %b want %b", k, done, (k == 17)); end
      nvec++; if (busy !== (k < 16)) begin nerr++; $display("FAIL burst_busy edge %0d got %b want %b", k, busy, (k < 16)); end
      nvec++; if (cfg_ready !== (k >= 17)) begin nerr++; $display("FAIL burst_ready edge %0d got %b want %b", k, cfg_ready, (k >= 17)); end
    end
    nvec++; if (spike_cnt !== 16'd4) begin nerr++; $display("FAIL burst_cnt got %0d want 4", spike_cnt); end
  endtask

  task automatic test_refrac();
    bit e, f, ed;
    int rc, n, sp, fin, last;
    rc = 0; n = 0; sp = 0; fin = 0; last = -100;
    load_cfg(8'd255, 1'b0, 8'd3, 4'd3);
    for (int k = 1; k <= 14; k++) begin
      ed = 1'b0; f = 1'b0;
      if (fin == 1) begin ed = 1'b1; fin = 2; end
      else if (fin == 0 && rc > 0) rc--;
      else if (fin == 0) begin
        n++; f = det_fire(n, 255);
        if (f) begin sp++; if (sp == 3) fin = 1; else rc = 3; end
      end
      exp_q.push_back(f);
      tick();
      e = exp_q.pop_front();
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL refrac_spike edge %0d got %b want %b", k, spike_out, e); end
      nvec++; if (done !== ed) begin nerr++; $display("FAIL refrac_done edge %0d got %b want %b", k, done, ed); end
      if (spike_out === 1'b1) begin
        nvec++; if (k - last < 4) begin nerr++; $display("FAIL refrac_gap edge %0d gap got %0d want >=4", k, k - last); end
        last = k;
      end
    end
  endtask

  task automatic test_stochastic();
    bit e;
    int expcnt;
    load_cfg(8'd0, 1'b1, 8'd0, 4'd0);
    for (int k = 0; k < 1000; k++) begin
      exp_q.push_back(1'b0);
      tick();
      e = exp_q.pop_front();
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL stoch0_spike cycle %0d got %b want 0", k, spike_out); end
    end
    nvec++; if (spike_cnt !== 16'd0) begin nerr++; $display("FAIL stoch0_cnt got %0d want 0", spike_cnt); end
    go_idle();
    load_cfg(8'd128, 1'b1, 8'd0, 4'd0);
    expcnt = 0;
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back(m_lfsr[7:0] < 8'd128);
      tick();
      e = exp_q.pop_front();
      expcnt += int'(e);
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL stoch128_spike cycle %0d got %b want %b", k, spike_out, e); end
    end
    nvec++; if (spike_cnt !== expcnt[15:0]) begin nerr++; $display("FAIL stoch128_cnt got %0d want %0d", spike_cnt, expcnt); end
    nvec++; if (spike_cnt < 16'd1948 || spike_cnt > 16'd2148) begin nerr++; $display("FAIL stoch128_range got %0d want 1948..2148", spike_cnt); end
    go_idle();
  endtask

  task automatic test_pause();
    bit e;
    int n;
    n = 0;
    load_cfg(8'd128, 1'b0, 8'd0, 4'd0);
    for (int k = 1; k <= 50; k++) begin
      enable = !(k > 20 && k <= 30);
      if (enable) begin n++; exp_q.push_back(det_fire(n, 128)); end
      else exp_q.push_back(1'b0);
      tick();
      e = exp_q.pop_front();
      nvec++; if (spike_out !== e) begin nerr++; $display("FAIL pause_spike edge %0d got %b want %b", k, spike_out, e); end
      if (k == 30) begin
        nvec++; if (spike_cnt !== 16'd10) begin nerr++; $display("FAIL pause_hold_cnt got %0d want 10", spike_cnt); end
      end
    end
    enable = 1'b1;
    nvec++; if (spike_cnt !== 16'd20) begin nerr++; $display("FAIL pause_cnt got %0d want 20", spike_cnt); end
    go_idle();
  endtask

  task automatic test_stop_on_fire();
    load_cfg(8'd128, 1'b0, 8'd0, 4'd0);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    nvec++; if (spike_out !== 1'b0) begin nerr++; $display("FAIL stop_spike got %b want 0", spike_out); end
    nvec++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL stop_idle ready/busy got %b%b want 10", cfg_ready, busy); end
    nvec++; if (spike_cnt !== 16'd1) begin nerr++; $display("FAIL stop_cnt got %0d want 1", spike_cnt); end
    tick();
    nvec++; if (spike_out !== 1'b0 || spike_cnt !== 16'd1) begin nerr++; $display("FAIL stop_hold spike/cnt got %b/%0d want 0/1", spike_out, spike_cnt); end
    cfg_valid = 1'b1; stop = 1'b1;
    tick();
    cfg_valid = 1'b0; stop = 1'b0;
    nvec++; if (busy !== 1'b1 || cfg_ready !== 1'b0 || spike_cnt !== 16'd0) begin
      nerr++; $display("FAIL cfg_with_stop busy/ready/cnt got %b%b/%0d want 10/0", busy, cfg_ready, spike_cnt);
    end
    go_idle();
  endtask

  task automatic test_rst_refrac();
    load_cfg(8'd255, 1'b0, 8'd8, 4'd3);
    tick(); tick(); tick();
    nvec++; if (busy !== 1'b1 || spike_cnt !== 16'd1) begin nerr++; $display("FAIL rstref_pre busy/cnt got %b/%0d want 1/1", busy, spike_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if ({cfg_ready, spike_out, busy, done} !== 4'b1000) begin
      nerr++; $display("FAIL rstref_outputs got %b%b%b%b want 1000", cfg_ready, spike_out, busy, done);
    end
    nvec++; if (spike_cnt !== 16'd0) begin nerr++; $display("FAIL rstref_cnt got %0d want 0", spike_cnt); end
    nvec++; if (dut.u_lfsr.state_o !== 16'hACE1) begin nerr++; $display("FAIL rstref_lfsr got %h want ace1", dut.u_lfsr.state_o); end
  endtask

  initial begin
    test_reset();
    test_det_rate128();
    test_burst();
    test_refrac();
    test_stochastic();
    test_pause();
    test_stop_on_fire();
    test_rst_refrac();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", nvec);
    $fatal(1);
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Transmitter end of the neuron's single-bit spike input.
- Converts an 8-bit rate value into a registered one-bit spike train that drives the LIF neuron's signal_in.
- Two modes: deterministic (phase-accumulator carry) and stochastic (LFSR compare).
- Optional refractory gap after each spike; optional finite burst length with a done pulse.

Parameters:
- WIDTH, 8: bit width of rate, accumulator and LFSR compare slice.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- CNT_W, 16: width of the saturating total-spike counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  encoder can accept config; high only in IDLE
- cfg_rate  in  WIDTH  spike rate, 0..2^WIDTH-1
- cfg_mode  in  1  0 = deterministic accumulator, 1 = stochastic LFSR
- cfg_count  in  8  burst length in spikes; 0 = continuous
- cfg_refrac  in  4  refractory cycles after each spike
- enable  in  1  run/pause gate
- stop  in  1  abort to IDLE
- spike_out  out  1  registered spike pulse to the neuron
- busy  out  1  state is RUN or REFRAC
- done  out  1  one-cycle pulse at burst completion
- spike_cnt  out  CNT_W  spikes emitted since last accepted config; saturating

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, cfg_ready=1, spike_out=0, busy=0, done=0, spike_cnt=0, acc=0, lfsr=LFSR_SEED, refrac counter=0, burst counter=0.
- A reset mid-operation aborts immediately to the reset values. No spike is emitted on the reset cycle.
- States are IDLE, RUN, REFRAC and DONE.
- IDLE:
  - A config is accepted at an edge where cfg_valid && cfg_ready.
  - On acceptance, latch rate, mode, count and refrac; set acc=0, spike_cnt=0, burst counter=0; go to RUN.
  - cfg_valid in any other state is ignored and not held.
- RUN, when enable=1, each edge:
  - Deterministic mode: {carry, acc} <= acc + rate, computed at WIDTH+1 bits; fire = carry.
  - Stochastic mode: fire = (lfsr[WIDTH-1:0] < rate), strict compare; acc unused.
  - spike_out <= fire. It is high for exactly the one cycle after the firing edge.
- Deterministic rate examples:
  - rate=0 never fires.
  - rate=128 fires every 2nd cycle; first spike_out high after the 2nd RUN edge.
  - rate=255 fires 255 of every 256 cycles.
- On fire:
  - spike_cnt increments, saturating at 2^CNT_W-1; burst counter increments.
  - If count!=0 and the burst counter reaches count, go to DONE. Refractory is skipped.
  - Else if refrac!=0, load the refractory counter with refrac and go to REFRAC.
- REFRAC:
  - acc is frozen, spike_out=0, the counter decrements once per enabled cycle.
  - Leave to RUN at the edge where the counter goes 1 to 0. A spike therefore cannot occur within refrac cycles of the previous spike.
- DONE: done=1 and spike_out=0 for one cycle, then go to IDLE. busy=0 in DONE.
- enable=0 in RUN or REFRAC pauses: all counters and acc hold, spike_out=0. The LFSR also holds.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances on every edge with enable=1, in any state, so the random sequence is independent of config timing.
- stop=1 in RUN, REFRAC or DONE: next state is IDLE, spike_out=0, done=0.
  - stop has priority over a simultaneous fire: no spike, no count.
  - spike_cnt holds its value until the next config is accepted.
- Simultaneous stop and cfg_valid in IDLE: the config is accepted and stop is ignored, because stop only acts outside IDLE.
- Output registration: spike_out, done and busy are registered, with no combinational path from inputs to these outputs. cfg_ready is a decode of the state register.

Decomposition:
- Package spike_enc_pkg holds:
  - state enum {IDLE, RUN, REFRAC, DONE};
  - MODE_DET=0 and MODE_STOCH=1 constants;
  - LFSR_TAPS=16'hB400 and the default LFSR_SEED.
- Sub-module spike_lfsr: 16-bit Galois LFSR with clk, rst, advance enable and state output. It is reused by the team's future Poisson stimulus blocks.

Test Plan:
- Reset released, cfg rate=128, mode=0, count=0, refrac=0, enable=1 -> spike_out high on alternate cycles, first pulse after the 2nd RUN edge; spike_cnt=50 after 100 RUN cycles.
- rate=64, count=4, refrac=0 -> exactly 4 pulses spaced 4 cycles apart, then one-cycle done, return to IDLE, cfg_ready=1.
- rate=255, refrac=3 -> each pulse is followed by at least 3 zero cycles; the last burst spike produces no refractory delay before DONE.
- mode=1, rate=0 for 1000 cycles -> no spikes; mode=1, rate=128 for 4096 cycles -> spike_cnt within 2048±100, matching the golden LFSR model exactly.
- Toggle enable low for 10 cycles mid-RUN with rate=128 -> output sequence is identical to the un-paused sequence shifted by 10 cycles; stop asserted on a firing cycle -> no spike, IDLE next cycle.
- rst asserted during REFRAC with count=8 -> next cycle all outputs at reset values, cfg_ready=1, LFSR back to 16'hACE1.
